// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered EX-stage ALU (exe_alu_pipe):
//   - 4-bit execute-command encodings
//   - handshake/multiply FSM state encoding
//   - bit positions of the {N,Z,C,V} status flags
// No ports; imported by exe_alu_pipe.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_FULL     = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Radix-2 shift-add multiplier returning the low WIDTH bits of a_i * b_i.
// One partial product per cycle, WIDTH iterations after the start cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        load operands and begin (ignored while abort_i is high)
//   abort_i        abandon the multiply in progress
//   a_i, b_i       operands, sampled on start_i
//   busy_o         iterations in progress
//   done_o         the current cycle performs the final iteration
//   product_o      accumulator including this cycle's partial product;
//                  holds the full product while done_o is high
// -----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Multiplicand bits shifted above WIDTH are dropped: only the low half of
  // the product is ever needed.
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_d;

endmodule

// File: rtl/exe_alu_pipe.sv
// -----------------------------------------------------------------------------
// exe_alu_pipe
// Registered EX-stage ALU with valid/ready on both sides, NZCV flags and an
// optional iterative multiply. Holds one result; a flush kills whatever is
// held or in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      kill held/in-flight operation, accept nothing
//   in_valid / in_ready        upstream handshake
//   exe_command                4-bit operation select
//   val1, val2                 operands
//   carry, v_in                current C and V flags
//   in_tag                     passthrough destination tag
//   out_valid / out_ready      downstream handshake
//   result, flags, out_tag     held result, {N,Z,C,V}, tag
//   out_err                    held result came from an illegal command
// -----------------------------------------------------------------------------
module exe_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_command,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             carry,
  input  logic             v_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;
  logic [3:0]       alu_flags;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Gated by rst_n so nothing is offered acceptance while reset is held.
  assign in_ready = rst_n && !flush &&
                    ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (exe_command == CMD_MUL);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath and flags
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = carry;
    alu_v   = v_in;
    alu_err = 1'b0;
    unique case (exe_command)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = val1 & val2;
      CMD_ORR: alu_res = val1 | val2;
      CMD_EOR: alu_res = val1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        ext = {1'b0, val1} + {1'b0, val2} +
              (WIDTH+1)'((exe_command == CMD_ADC) && carry);
        alu_res = ext[MSB:0];
        alu_c   = ext[WIDTH];
        alu_v   = (val1[MSB] == val2[MSB]) && (alu_res[MSB] != val1[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        ext = {1'b0, val1} - {1'b0, val2} -
              (WIDTH+1)'((exe_command == CMD_SBC) && !carry);
        alu_res = ext[MSB:0];
        // Bit WIDTH of the extended difference is the borrow; ARM C is its
        // inverse.
        alu_c   = !ext[WIDTH];
        alu_v   = (val1[MSB] != val2[MSB]) && (alu_res[MSB] != val1[MSB]);
      end
      // Handled by the multiplier when present; otherwise an illegal command.
      CMD_MUL: alu_err = !MUL_EN;
      default: alu_err = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------------
  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && is_mul),
        .abort_i  (flush),
        .a_i      (val1),
        .b_i      (val2),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) state_d = is_mul ? ST_MUL_BUSY : ST_FULL;
        end
        ST_MUL_BUSY: begin
          if (mul_done)      state_d = ST_FULL;
          else if (!mul_busy) state_d = ST_EMPTY;
        end
        ST_FULL: begin
          if (out_ready) begin
            if (accept) state_d = is_mul ? ST_MUL_BUSY : ST_FULL;
            else        state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output register. Loads only on accept (which requires the old result to
  // be consumed) or on multiply completion, so a stalled result never moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      flags_q  <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q <= in_tag;
        if (is_mul) begin
          // C and V pass through a multiply, so capture them at issue time.
          flags_q[FLAG_N] <= 1'b0;
          flags_q[FLAG_Z] <= 1'b0;
          flags_q[FLAG_C] <= carry;
          flags_q[FLAG_V] <= v_in;
          err_q           <= 1'b0;
        end else begin
          result_q <= alu_res;
          flags_q  <= alu_flags;
          err_q    <= alu_err;
        end
      end else if ((state_q == ST_MUL_BUSY) && mul_done && !flush) begin
        result_q        <= mul_product;
        flags_q[FLAG_N] <= mul_product[MSB];
        flags_q[FLAG_Z] <= (mul_product == '0);
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule
